// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 scan-code receiver.
//   state_t   receiver FSM states
//   SC_*      set-2 prefix bytes and the default tracked key
//   FRAME_LEN bits per device-to-host frame (start, 8 data, parity, stop)
//   cnt_width width of a counter that must hold 0..max_count
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam int         FRAME_LEN = 11;

  // $clog2(1) is 0, so keep at least one bit for degenerate parameter sets.
  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// ps2_clk_filter: brings the asynchronous PS/2 clock pin into the clk domain,
// debounces it and reports its falling edges.
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   ps2c   in  PS/2 clock pin, asynchronous
//   fall   out one-cycle strobe when the filtered level goes 1 -> 0
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2c,
  output logic fall
);

  logic                  meta;
  logic                  sync;
  logic [FILTER_LEN-1:0] taps;
  logic                  level;

  // The filtered level only moves when every tap agrees, so any pulse
  // shorter than FILTER_LEN samples leaves it untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta  <= 1'b1;
      sync  <= 1'b1;
      taps  <= '1;
      level <= 1'b1;
      fall  <= 1'b0;
    end else begin
      meta <= ps2c;
      sync <= meta;
      taps <= {taps[FILTER_LEN-2:0], sync};
      fall <= 1'b0;
      if (&taps) begin
        level <= 1'b1;
      end else if (~|taps) begin
        level <= 1'b0;
        fall  <= level;
      end
    end
  end

endmodule

// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx: PS/2 device-to-host receiver and set-2 scan-code decoder.
// Frames 11-bit packets, checks start/parity/stop, folds E0/F0 prefixes into
// flags on the next code and tracks one "hold key" with a release hold-off.
//   clk, rst_n        system clock, asynchronous active-low reset
//   ps2c, ps2d        PS/2 clock and data pins (asynchronous)
//   code_valid        one-cycle strobe, code/code_ext/code_brk valid
//   code              scan code without prefixes
//   code_ext/code_brk code was preceded by E0 / F0
//   parity_err        one-cycle strobe, frame dropped on parity mismatch
//   frame_err         one-cycle strobe, bad start/stop or inter-bit timeout
//   key_held          level, HOLD_KEY currently down
//   key_press         one-cycle strobe on a new HOLD_KEY press
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int         CLK_HZ     = 50_000_000,
  parameter int         FILTER_LEN = 8,
  parameter int         TIMEOUT_US = 2000,
  parameter logic [7:0] HOLD_KEY   = SC_SPACE,
  parameter int         HOLDOFF_MS = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic       code_valid,
  output logic [7:0] code,
  output logic       code_ext,
  output logic       code_brk,
  output logic       parity_err,
  output logic       frame_err,
  output logic       key_held,
  output logic       key_press
);

  // 64-bit intermediates: TIMEOUT_US*CLK_HZ overflows 32 bits at 50 MHz.
  localparam int TO_CYCLES = int'(longint'(TIMEOUT_US) * longint'(CLK_HZ) / longint'(1_000_000));
  localparam int HO_CYCLES = int'(longint'(HOLDOFF_MS) * longint'(CLK_HZ) / longint'(1000));
  localparam int TO_W      = cnt_width(TO_CYCLES);
  localparam int HO_W      = cnt_width(HO_CYCLES);

  logic                 fall;
  logic                 d_meta;
  logic                 d_sync;
  state_t               state;
  logic [FRAME_LEN-1:0] frame_bits;
  logic [3:0]           bit_cnt;
  logic [TO_W-1:0]      to_cnt;
  logic [HO_W-1:0]      holdoff_cnt;
  logic                 ext_f;
  logic                 brk_f;
  logic [7:0]           data;

  ps2_clk_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_clk_filter (
    .clk   (clk),
    .rst_n (rst_n),
    .ps2c  (ps2c),
    .fall  (fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_meta <= 1'b1;
      d_sync <= 1'b1;
    end else begin
      d_meta <= ps2d;
      d_sync <= d_meta;
    end
  end

  // After FRAME_LEN LSB-first shifts: [0]=start, [8:1]=data, [9]=parity, [10]=stop.
  assign data = frame_bits[8:1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      frame_bits  <= '0;
      bit_cnt     <= '0;
      to_cnt      <= '0;
      holdoff_cnt <= '0;
      ext_f       <= 1'b0;
      brk_f       <= 1'b0;
      code_valid  <= 1'b0;
      code        <= '0;
      code_ext    <= 1'b0;
      code_brk    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      key_held    <= 1'b0;
      key_press   <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      key_press  <= 1'b0;

      // Free-running hold-off; a break in CHECK below overrides this reload.
      if (holdoff_cnt != '0) begin
        holdoff_cnt <= holdoff_cnt - HO_W'(1);
      end

      case (state)
        ST_IDLE: begin
          if (fall) begin
            frame_bits <= {d_sync, frame_bits[FRAME_LEN-1:1]};
            bit_cnt    <= 4'd1;
            to_cnt     <= TO_W'(TO_CYCLES);
            state      <= ST_RECV;
          end
        end

        ST_RECV: begin
          if (fall) begin
            frame_bits <= {d_sync, frame_bits[FRAME_LEN-1:1]};
            bit_cnt    <= bit_cnt + 4'd1;
            to_cnt     <= TO_W'(TO_CYCLES);
            if (bit_cnt == 4'(FRAME_LEN - 1)) begin
              state <= ST_CHECK;
            end
          end else if (to_cnt == '0) begin
            // Stalled device: drop the partial frame and any pending prefix.
            frame_err <= 1'b1;
            ext_f     <= 1'b0;
            brk_f     <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            to_cnt <= to_cnt - TO_W'(1);
          end
        end

        ST_CHECK: begin
          state <= ST_IDLE;
          if (frame_bits[0] != 1'b0 || frame_bits[FRAME_LEN-1] != 1'b1) begin
            frame_err <= 1'b1;
            ext_f     <= 1'b0;
            brk_f     <= 1'b0;
          end else if (^frame_bits[9:1] != 1'b1) begin
            parity_err <= 1'b1;
            ext_f      <= 1'b0;
            brk_f      <= 1'b0;
          end else if (data == SC_EXT) begin
            ext_f <= 1'b1;
          end else if (data == SC_BRK) begin
            brk_f <= 1'b1;
          end else begin
            code_valid <= 1'b1;
            code       <= data;
            code_ext   <= ext_f;
            code_brk   <= brk_f;
            ext_f      <= 1'b0;
            brk_f      <= 1'b0;
            // Extended codes that share the byte value are different keys.
            if (data == HOLD_KEY && !ext_f) begin
              if (brk_f) begin
                key_held    <= 1'b0;
                holdoff_cnt <= HO_W'(HO_CYCLES);
              end else if (!key_held && holdoff_cnt == '0) begin
                key_held  <= 1'b1;
                key_press <= 1'b1;
              end
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
module tb_ps2_scancode_rx;

  localparam int         CLK_HZ     = 1_000_000;
  localparam int         FILTER_LEN = 8;
  localparam int         TIMEOUT_US = 2000;
  localparam logic [7:0] HOLD_KEY   = 8'h29;
  localparam int         HOLDOFF_MS = 10;
  localparam int         TO_CYC     = TIMEOUT_US * (CLK_HZ / 1_000_000);
  localparam int         HO_CYC     = HOLDOFF_MS * (CLK_HZ / 1000);
  localparam int         H          = 20;   // half bit period, clk cycles
  // Pin-to-strobe: 2 sync stages, FILTER_LEN agreeing samples, registered
  // fall, then code_valid 2 clk after that fall.
  localparam int         LAT        = 2 + FILTER_LEN + 1 + 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2c = 1'b1;
  logic       ps2d = 1'b1;
  logic       code_valid;
  logic [7:0] code;
  logic       code_ext, code_brk, parity_err, frame_err, key_held, key_press;

  ps2_scancode_rx #(
    .CLK_HZ(CLK_HZ), .FILTER_LEN(FILTER_LEN), .TIMEOUT_US(TIMEOUT_US),
    .HOLD_KEY(HOLD_KEY), .HOLDOFF_MS(HOLDOFF_MS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ps2c(ps2c), .ps2d(ps2d),
    .code_valid(code_valid), .code(code), .code_ext(code_ext), .code_brk(code_brk),
    .parity_err(parity_err), .frame_err(frame_err),
    .key_held(key_held), .key_press(key_press)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Observed events
  logic [9:0] mon_q[$];
  int         mon_perr = 0, mon_ferr = 0, mon_press = 0, mon_orphan = 0;
  longint     last_valid_cyc = -1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (code_valid) begin
        mon_q.push_back({code_ext, code_brk, code});
        last_valid_cyc = cyc;
      end
      if (parity_err) mon_perr++;
      if (frame_err) mon_ferr++;
      if (key_press) begin
        mon_press++;
        if (!code_valid) mon_orphan++;
      end
    end
  end

  // Reference model: what a set-2 decoder should report for each frame
  logic [9:0] exp_q[$];
  int         exp_perr = 0, exp_ferr = 0, exp_press = 0;
  logic       m_ext = 1'b0, m_brk = 1'b0, m_held = 1'b0;
  longint     m_ho_end = 0;
  longint     stop_cyc = 0;

  task automatic model_reset();
    m_ext = 1'b0; m_brk = 1'b0; m_held = 1'b0; m_ho_end = 0;
  endtask

  // kind: 0 good, 1 bad parity, 2 bad stop; t = cycle the code is reported
  task automatic model_frame(input logic [7:0] b, input int kind, input longint t);
    if (kind != 0) begin
      if (kind == 1) exp_perr++;
      else exp_ferr++;
      m_ext = 1'b0; m_brk = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      exp_q.push_back({m_ext, m_brk, b});
      if (b == HOLD_KEY && !m_ext) begin
        if (m_brk) begin
          m_held = 1'b0;
          m_ho_end = t + HO_CYC;
        end else if (!m_held && t >= m_ho_end) begin
          m_held = 1'b1;
          exp_press++;
        end
      end
      m_ext = 1'b0; m_brk = 1'b0;
    end
  endtask

  // Drives the first n bits of a frame (index 0 first), then idles.
  task automatic send_bits(input logic [10:0] bits, input int n, input int idle);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); ps2d = bits[i];
      repeat (H) @(negedge clk);
      ps2c = 1'b0; stop_cyc = cyc;
      repeat (H) @(negedge clk);
      ps2c = 1'b1;
    end
    @(negedge clk); ps2d = 1'b1;
    repeat (idle) @(negedge clk);
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input int kind);
    logic par;
    logic stp;
    par = ~(^b);
    if (kind == 1) par = ~par;
    stp = (kind == 2) ? 1'b0 : 1'b1;
    return {stp, par, b, 1'b0};
  endfunction

  task automatic send_frame(input logic [7:0] b, input int kind, input int idle);
    send_bits(make_frame(b, kind), 11, idle);
    model_frame(b, kind, stop_cyc + LAT);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (code_valid !== 1'b0) begin failures++; $display("FAIL reset_code_valid got=%b want=0", code_valid); end
    checks++; if (code !== 8'h00) begin failures++; $display("FAIL reset_code got=%h want=00", code); end
    checks++; if (code_ext !== 1'b0 || code_brk !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b want=00", code_ext, code_brk); end
    checks++; if (parity_err !== 1'b0 || frame_err !== 1'b0) begin failures++; $display("FAIL reset_errs got=%b%b want=00", parity_err, frame_err); end
    checks++; if (key_held !== 1'b0 || key_press !== 1'b0) begin failures++; $display("FAIL reset_key got=%b%b want=00", key_held, key_press); end
  endtask

  task automatic test_basic();
    logic [9:0] got;
    send_frame(8'h1C, 0, 2 * H);
    checks++; if (mon_q.size() !== exp_q.size()) begin failures++; $display("FAIL basic_count got=%0d want=%0d", mon_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < mon_q.size()) ? mon_q[i] : 10'bx;
      checks++; if (got !== exp_q[i]) begin failures++; $display("FAIL basic_code[%0d] got=%h want=%h", i, got, exp_q[i]); end
    end
    checks++; if (last_valid_cyc - stop_cyc !== longint'(LAT)) begin failures++; $display("FAIL basic_latency got=%0d want=%0d", last_valid_cyc - stop_cyc, LAT); end
    checks++; if (mon_perr !== exp_perr || mon_ferr !== exp_ferr) begin failures++; $display("FAIL basic_errs got=%0d/%0d want=%0d/%0d", mon_perr, mon_ferr, exp_perr, exp_ferr); end
    $display("basic: code 1C latency=%0d", last_valid_cyc - stop_cyc);
    mon_q.delete(); exp_q.delete();
  endtask

  task automatic test_prefix();
    logic [9:0] got;
    send_frame(8'hE0, 0, 2 * H);
    send_frame(8'hF0, 0, 2 * H);
    send_frame(8'h75, 0, 2 * H);
    checks++; if (mon_q.size() !== exp_q.size()) begin failures++; $display("FAIL prefix_count got=%0d want=%0d", mon_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < mon_q.size()) ? mon_q[i] : 10'bx;
      checks++; if (got !== exp_q[i]) begin failures++; $display("FAIL prefix_code[%0d] got=%h want=%h", i, got, exp_q[i]); end
    end
    $display("prefix: E0 F0 75 -> %0d strobe(s)", mon_q.size());
    mon_q.delete(); exp_q.delete();
  endtask

  task automatic test_hold();
    logic [7:0] seq [5] = '{8'h29, 8'h29, 8'h29, 8'hF0, 8'h29};
    logic [9:0] got;
    for (int i = 0; i < 5; i++) begin
      send_frame(seq[i], 0, 2 * H);
      checks++; if (key_held !== m_held) begin failures++; $display("FAIL hold_held[%0d] got=%b want=%b", i, key_held, m_held); end
    end
    checks++; if (mon_press !== exp_press) begin failures++; $display("FAIL hold_press got=%0d want=%0d", mon_press, exp_press); end
    checks++; if (mon_orphan !== 0) begin failures++; $display("FAIL hold_press_align got=%0d want=0", mon_orphan); end
    checks++; if (mon_q.size() !== exp_q.size()) begin failures++; $display("FAIL hold_count got=%0d want=%0d", mon_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < mon_q.size()) ? mon_q[i] : 10'bx;
      checks++; if (got !== exp_q[i]) begin failures++; $display("FAIL hold_code[%0d] got=%h want=%h", i, got, exp_q[i]); end
    end
    $display("hold: presses=%0d codes=%0d", mon_press, mon_q.size());
    mon_q.delete(); exp_q.delete();
  endtask

  task automatic test_holdoff();
    longint target;
    send_frame(8'h29, 0, 2 * H);   // still inside the hold-off window
    checks++; if (mon_q.size() !== 1) begin failures++; $display("FAIL holdoff_early_valid got=%0d want=1", mon_q.size()); end
    checks++; if (mon_press !== exp_press || key_held !== m_held) begin failures++; $display("FAIL holdoff_early got=%0d/%b want=%0d/%b", mon_press, key_held, exp_press, m_held); end
    target = m_ho_end + 200;
    while (cyc < target) @(negedge clk);
    send_frame(8'h29, 0, 2 * H);
    checks++; if (mon_press !== exp_press || key_held !== m_held) begin failures++; $display("FAIL holdoff_late got=%0d/%b want=%0d/%b", mon_press, key_held, exp_press, m_held); end
    send_frame(8'hF0, 0, 2 * H);
    send_frame(8'h29, 0, 2 * H);
    checks++; if (key_held !== m_held) begin failures++; $display("FAIL holdoff_release got=%b want=%b", key_held, m_held); end
    $display("holdoff: presses=%0d held=%b", mon_press, key_held);
    mon_q.delete(); exp_q.delete();
  endtask

  task automatic test_errors();
    logic [9:0] got;
    for (int k = 1; k <= 2; k++) begin
      send_frame(8'hE0, 0, 2 * H);
      send_frame(8'h1C, k, 2 * H);
      checks++; if (mon_perr !== exp_perr || mon_ferr !== exp_ferr) begin failures++; $display("FAIL err_kind%0d got=%0d/%0d want=%0d/%0d", k, mon_perr, mon_ferr, exp_perr, exp_ferr); end
      send_frame(8'hF0, 0, 2 * H);
      send_frame(8'h1C, 0, 2 * H);
      checks++; if (mon_q.size() !== exp_q.size()) begin failures++; $display("FAIL err_count%0d got=%0d want=%0d", k, mon_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
        got = (i < mon_q.size()) ? mon_q[i] : 10'bx;
        checks++; if (got !== exp_q[i]) begin failures++; $display("FAIL err_code%0d[%0d] got=%h want=%h", k, i, got, exp_q[i]); end
      end
      $display("errors: kind %0d perr=%0d ferr=%0d", k, mon_perr, mon_ferr);
      mon_q.delete(); exp_q.delete();
    end
  endtask

  task automatic test_timeout();
    logic [9:0] got;
    send_frame(8'hE0, 0, 2 * H);
    send_bits(make_frame(8'h1C, 0), 5, 0);
    repeat (TO_CYC + 300) @(negedge clk);
    exp_ferr++; m_ext = 1'b0; m_brk = 1'b0;
    checks++; if (mon_ferr !== exp_ferr || mon_perr !== exp_perr) begin failures++; $display("FAIL timeout_err got=%0d/%0d want=%0d/%0d", mon_perr, mon_ferr, exp_perr, exp_ferr); end
    send_frame(8'h1C, 0, 2 * H);
    checks++; if (mon_q.size() !== exp_q.size()) begin failures++; $display("FAIL timeout_count got=%0d want=%0d", mon_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < mon_q.size()) ? mon_q[i] : 10'bx;
      checks++; if (got !== exp_q[i]) begin failures++; $display("FAIL timeout_code[%0d] got=%h want=%h", i, got, exp_q[i]); end
    end
    $display("timeout: ferr=%0d next code=%h", mon_ferr, (mon_q.size() > 0) ? mon_q[0] : 10'h0);
    mon_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    logic [9:0] got;
    send_frame(8'hE0, 0, 2 * H);
    send_bits(make_frame(8'h1C, 0), 4, 0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (2 * H) @(negedge clk);
    checks++; if (mon_perr !== exp_perr || mon_ferr !== exp_ferr || mon_q.size() !== 0) begin failures++; $display("FAIL rstmid_strobes got=%0d/%0d/%0d want=%0d/%0d/0", mon_perr, mon_ferr, mon_q.size(), exp_perr, exp_ferr); end
    send_frame(8'h1C, 0, 2 * H);
    checks++; if (mon_q.size() !== exp_q.size()) begin failures++; $display("FAIL rstmid_count got=%0d want=%0d", mon_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < mon_q.size()) ? mon_q[i] : 10'bx;
      checks++; if (got !== exp_q[i]) begin failures++; $display("FAIL rstmid_code[%0d] got=%h want=%h", i, got, exp_q[i]); end
    end
    $display("reset_mid: next code count=%0d", mon_q.size());
    mon_q.delete(); exp_q.delete();
  endtask

  task automatic test_glitch();
    logic [9:0] got;
    @(negedge clk); ps2c = 1'b0;
    repeat (3) @(negedge clk);
    ps2c = 1'b1;
    repeat (TO_CYC + 300) @(negedge clk);
    checks++; if (mon_ferr !== exp_ferr || mon_perr !== exp_perr || mon_q.size() !== 0) begin failures++; $display("FAIL glitch_strobes got=%0d/%0d/%0d want=%0d/%0d/0", mon_perr, mon_ferr, mon_q.size(), exp_perr, exp_ferr); end
    send_frame(8'h32, 0, 2 * H);
    checks++; if (mon_q.size() !== exp_q.size()) begin failures++; $display("FAIL glitch_count got=%0d want=%0d", mon_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < mon_q.size()) ? mon_q[i] : 10'bx;
      checks++; if (got !== exp_q[i]) begin failures++; $display("FAIL glitch_code[%0d] got=%h want=%h", i, got, exp_q[i]); end
    end
    $display("glitch: codes=%0d", mon_q.size());
    mon_q.delete(); exp_q.delete();
  endtask

  // Random prefixes, codes and occasional parity errors; back_to_back
  // selects zero idle between frames.
  task automatic test_stream(input int n, input logic back_to_back);
    logic [9:0] got;
    logic [7:0] b;
    int         gap;
    for (int t = 0; t < n; t++) begin
      b = 8'($urandom_range(1, 8'h83));
      if (b == HOLD_KEY) b = 8'h1C;
      gap = back_to_back ? 0 : int'($urandom_range(0, H));
      if ($urandom_range(0, 1) == 1) send_frame(8'hE0, 0, gap);
      if ($urandom_range(0, 1) == 1) send_frame(8'hF0, 0, gap);
      send_frame(b, ($urandom_range(0, 7) == 0) ? 1 : 0, gap);
    end
    repeat (2 * H) @(negedge clk);
    checks++; if (mon_perr !== exp_perr || mon_ferr !== exp_ferr) begin failures++; $display("FAIL stream_errs got=%0d/%0d want=%0d/%0d", mon_perr, mon_ferr, exp_perr, exp_ferr); end
    checks++; if (mon_q.size() !== exp_q.size()) begin failures++; $display("FAIL stream_count got=%0d want=%0d", mon_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < mon_q.size()) ? mon_q[i] : 10'bx;
      checks++; if (got !== exp_q[i]) begin failures++; $display("FAIL stream_code[%0d] got=%h want=%h", i, got, exp_q[i]); end
    end
    $display("stream: b2b=%b codes=%0d perr=%0d", back_to_back, mon_q.size(), mon_perr);
    mon_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_prefix();
    test_hold();
    test_holdoff();
    test_errors();
    test_timeout();
    test_reset_mid();
    test_glitch();
    test_stream(12, 1'b0);
    test_stream(6, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
